// File: rtl/mult_shift_add_n.sv
// Sequential shift-add multiplier: X:A:B datapath with a Moore control FSM.
// One add/subtract step plus one shift step per multiplier bit, so latency is fixed.
module mult_shift_add_n #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Run,
  input  logic             ClearA_LoadB,
  input  logic             Signed_Mode,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             Xval,
  output logic             Busy,
  output logic             Done
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, DONE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic             x_q, sgn_q;
  logic [CW-1:0]    cnt_q;
  logic             last;
  logic [WIDTH:0]   a_ext, s_ext, sum;

  assign last = (cnt_q == LAST);

  // The final signed step carries the weight -2^(W-1), hence the subtract.
  always_comb begin
    a_ext = sgn_q ? {a_q[WIDTH-1], a_q} : {1'b0, a_q};
    s_ext = sgn_q ? {s_q[WIDTH-1], s_q} : {1'b0, s_q};
    sum   = (last && sgn_q) ? (a_ext - s_ext) : (a_ext + s_ext);
  end

  always_ff @(posedge Clk) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    Busy      = 1'b0;
    Done      = 1'b0;
    case (state)
      IDLE:    if (!ClearA_LoadB && Run) state_nxt = CLR;
      CLR:     begin Busy = 1'b1; state_nxt = ADD; end
      ADD:     begin Busy = 1'b1; state_nxt = SHIFT; end
      SHIFT:   begin Busy = 1'b1; state_nxt = last ? DONE : ADD; end
      DONE:    begin Done = 1'b1; if (!Run) state_nxt = IDLE; end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      a_q   <= '0;
      x_q   <= 1'b0;
      b_q   <= D;
      cnt_q <= '0;
      s_q   <= '0;
      sgn_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (ClearA_LoadB) begin
            a_q <= '0;
            x_q <= 1'b0;
            b_q <= D;
          end else if (Run) begin
            sgn_q <= Signed_Mode;
            s_q   <= D;
            cnt_q <= '0;
          end
        end
        CLR: begin
          a_q <= '0;
          x_q <= 1'b0;
        end
        ADD: if (b_q[0]) {x_q, a_q} <= sum;
        SHIFT: begin
          a_q <= {x_q, a_q[WIDTH-1:1]};
          b_q <= {a_q[0], b_q[WIDTH-1:1]};
          if (!sgn_q) x_q <= 1'b0;
          if (!last) cnt_q <= cnt_q + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign Aval = a_q;
  assign Bval = b_q;
  assign Xval = x_q;
endmodule

// File: tb/tb_mult_shift_add_n.sv
// Scoreboarded bench for mult_shift_add_n at WIDTH 4, 8 and 16; directed cases on the 8-bit unit.
module tb_mult_shift_add_n;
  typedef struct {
    logic [31:0] prod;
    logic        x;
    int          cyc;
  } exp_t;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic [2:0]  run = '0, cab = '0, sm = '0;
  logic [15:0] d [3];
  logic [3:0]  a4, b4;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic [2:0]  xv, busy, done;
  logic [2:0]  pdone = '0;
  logic [15:0] bm [3];
  exp_t        sbq [3][$];
  exp_t        me;
  int          cyc = 0, n_chk = 0, n_fail = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  mult_shift_add_n #(.WIDTH(4)) u4 (
    .Clk(Clk), .Reset(Reset), .Run(run[0]), .ClearA_LoadB(cab[0]), .Signed_Mode(sm[0]),
    .D(d[0][3:0]), .Aval(a4), .Bval(b4), .Xval(xv[0]), .Busy(busy[0]), .Done(done[0]));
  mult_shift_add_n #(.WIDTH(8)) u8 (
    .Clk(Clk), .Reset(Reset), .Run(run[1]), .ClearA_LoadB(cab[1]), .Signed_Mode(sm[1]),
    .D(d[1][7:0]), .Aval(a8), .Bval(b8), .Xval(xv[1]), .Busy(busy[1]), .Done(done[1]));
  mult_shift_add_n #(.WIDTH(16)) u16 (
    .Clk(Clk), .Reset(Reset), .Run(run[2]), .ClearA_LoadB(cab[2]), .Signed_Mode(sm[2]),
    .D(d[2]), .Aval(a16), .Bval(b16), .Xval(xv[2]), .Busy(busy[2]), .Done(done[2]));

  function automatic int wid(int i);
    return 4 << i;
  endfunction

  function automatic logic [15:0] msk(int i, logic [15:0] v);
    return v & 16'((32'd1 << wid(i)) - 1);
  endfunction

  function automatic longint rd_ab(int i);
    case (i)
      0:       return longint'({a4, b4});
      1:       return longint'({a8, b8});
      default: return longint'({a16, b16});
    endcase
  endfunction

  // Reference: plain integer product of the interpreted operands, truncated to 2W bits.
  function automatic void ref_mul(int w, bit sg, logic [15:0] s, logic [15:0] b,
                                  output logic [31:0] p, output logic x);
    longint sv, bv, pr;
    sv = longint'(s);
    bv = longint'(b);
    if (sg) begin
      if (sv >= (longint'(1) << (w - 1))) sv = sv - (longint'(1) << w);
      if (bv >= (longint'(1) << (w - 1))) bv = bv - (longint'(1) << w);
    end
    pr = sv * bv;
    p  = 32'(pr & ((longint'(1) << (2 * w)) - 1));
    x  = sg && (pr < 0);
  endfunction

  task automatic chk(string nm, longint got, longint exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: every rising Done is matched against the oldest expectation.
  always @(negedge Clk) begin
    for (int i = 0; i < 3; i++) begin
      if (done[i] && !pdone[i]) begin
        if (sbq[i].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done w%0d: got Done=1 expected no result", wid(i));
        end else begin
          me = sbq[i].pop_front();
          chk($sformatf("prod_w%0d", wid(i)), rd_ab(i), longint'(me.prod));
          chk($sformatf("x_w%0d", wid(i)), longint'(xv[i]), longint'(me.x));
          chk($sformatf("latency_w%0d", wid(i)), longint'(cyc), longint'(me.cyc));
        end
      end
      pdone[i] = done[i];
    end
  end

  task automatic load(int i, logic [15:0] v, bit with_run);
    @(negedge Clk);
    cab[i] = 1'b1;
    d[i]   = v;
    run[i] = with_run;
    @(negedge Clk);
    cab[i] = 1'b0;
    run[i] = 1'b0;
    bm[i]  = msk(i, v);
    chk("load_b", rd_ab(i) & longint'(msk(i, 16'hFFFF)), longint'(msk(i, v)));
    chk("load_a", rd_ab(i) >> wid(i), 0);
    chk("load_busy", longint'(busy[i]), 0);
  endtask

  task automatic mult(int i, bit sg, logic [15:0] s, int hold);
    logic [31:0] p;
    logic        x;
    exp_t        e;
    int          k;
    @(negedge Clk);
    sm[i]  = sg;
    d[i]   = s;
    run[i] = 1'b1;
    ref_mul(wid(i), sg, msk(i, s), bm[i], p, x);
    e.prod = p;
    e.x    = x;
    e.cyc  = cyc + 2 * wid(i) + 2;
    sbq[i].push_back(e);
    bm[i]  = msk(i, p[15:0]);
    @(negedge Clk);
    chk("busy_start", longint'(busy[i]), 1);
    chk("done_start", longint'(done[i]), 0);
    if (hold == 0) run[i] = 1'b0;
    d[i]  = 16'($urandom);
    sm[i] = ~sg;
    k = 0;
    while (!done[i] && k < 2 * wid(i) + 8) begin
      @(negedge Clk);
      k++;
    end
    if (!done[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL done_timeout w%0d: got no Done expected Done within %0d cycles", wid(i), k);
      void'(sbq[i].pop_back());
    end
    if (hold > 0) begin
      repeat (hold) @(negedge Clk);
      chk("hold_done", longint'(done[i]), 1);
      chk("hold_busy", longint'(busy[i]), 0);
      chk("hold_single", longint'(sbq[i].size()), 0);
      run[i] = 1'b0;
    end
    @(negedge Clk);
    chk("back_idle", longint'(done[i] | busy[i]), 0);
  endtask

  initial begin
    d[0] = 16'h005A; d[1] = 16'h005A; d[2] = 16'h005A;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rst_a", rd_ab(i) >> wid(i), 0);
      chk("rst_b", rd_ab(i) & longint'(msk(i, 16'hFFFF)), longint'(msk(i, 16'h005A)));
      chk("rst_x", longint'(xv[i]), 0);
      chk("rst_busy_done", longint'(busy[i] | done[i]), 0);
      bm[i] = msk(i, 16'h005A);
    end

    load(1, 16'h3B, 1'b0); mult(1, 1'b1, 16'h07, 0);
    chk("t1", rd_ab(1), 'h019D);
    load(1, 16'hC5, 1'b0); mult(1, 1'b1, 16'hF9, 0);
    chk("t2a", rd_ab(1), 'h019D);
    load(1, 16'hC5, 1'b0); mult(1, 1'b1, 16'h07, 0);
    chk("t2b", rd_ab(1), 'hFE63);
    chk("t2b_x", longint'(xv[1]), 1);
    load(1, 16'hFF, 1'b0); mult(1, 1'b0, 16'hFF, 0);
    chk("t3a", rd_ab(1), 'hFE01);
    load(1, 16'h80, 1'b0); mult(1, 1'b1, 16'h80, 0);
    chk("t3b", rd_ab(1), 'h4000);

    load(1, 16'h3B, 1'b0); mult(1, 1'b1, 16'h07, 40);
    mult(1, 1'b1, 16'h02, 0);
    chk("t4_repress", rd_ab(1), 'hFF3A);

    // Reset in the middle of a run reloads B from D and aborts.
    @(negedge Clk);
    sm[1] = 1'b0; d[1] = 16'h55; run[1] = 1'b1;
    repeat (7) @(negedge Clk);
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) bm[i] = msk(i, d[i]);
    @(negedge Clk);
    Reset = 1'b0; run[1] = 1'b0;
    chk("t5_a", rd_ab(1) >> 8, 0);
    chk("t5_b", rd_ab(1) & 'hFF, 'h55);
    chk("t5_x", longint'(xv[1]), 0);
    chk("t5_busy", longint'(busy[1] | done[1]), 0);

    load(1, 16'h21, 1'b1);
    repeat (3) @(negedge Clk);
    chk("t5_no_start", longint'(busy[1] | done[1]), 0);

    for (int i = 0; i < 3; i++) begin
      load(i, 16'(32'd1 << (wid(i) - 1)), 1'b0);
      mult(i, 1'b1, 16'(32'd1 << (wid(i) - 1)), 0);
      for (int n = 0; n < 25; n++) begin
        if ($urandom_range(3) == 0) load(i, 16'($urandom), 1'b0);
        mult(i, 1'($urandom_range(1)), 16'($urandom), 0);
      end
    end

    repeat (3) @(negedge Clk);
    for (int i = 0; i < 3; i++) chk("sb_empty", longint'(sbq[i].size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
